// File: rtl/serial_neg_pkg.sv
// Shared definitions for the serial two's-complement negator.
// Contents:
//   W_DEFAULT  default operand width
//   state_t    controller state encoding (IDLE=0, SHIFT=1, DONE=2)
//   cnt_width  bit counter width able to hold 0..w without wrapping
package serial_neg_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_neg_ctrl_if.sv
// Request/result bundle between a client and serial_neg_ctrl.
// Signals:
//   start  request to negate din (client -> controller)
//   din    W-bit two's-complement operand (client -> controller)
//   busy   controller is in SHIFT or DONE (controller -> client)
//   done   one-cycle completion pulse (controller -> client)
//   dout   W-bit result -din mod 2^W, held until the next done
//   ovf    operand was the most-negative value
// Modports: master = client side, slave = controller side.
interface serial_neg_ctrl_if
    import serial_neg_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic         start;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         ovf;

    modport master (
        output start, din,
        input  busy, done, dout, ovf
    );

    modport slave (
        input  start, din,
        output busy, done, dout, ovf
    );
endinterface

// File: rtl/serial_neg_cell.sv
// Bit-serial two's-complement negation cell, operand fed LSB first.
// Bits up to and including the first 1 pass unchanged; every later bit
// is inverted.
// Ports:
//   clk      rising-edge clock
//   res      synchronous active-high reset (clears seen_one)
//   clr      clears seen_one at the start of a new word
//   en       advance the cell state this cycle
//   in_bit   current operand bit
//   out_bit  current result bit (combinational)
module serial_neg_cell (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    input  logic in_bit,
    output logic out_bit
);
    logic seen_one;

    always_comb begin
        out_bit = in_bit ^ seen_one;
    end

    always_ff @(posedge clk) begin
        if (res || clr) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | in_bit;
        end
    end
endmodule

// File: rtl/serial_neg_ctrl.sv
// Serial negation controller: accepts a W-bit operand on start, streams
// it LSB-first through serial_neg_cell over W cycles, then presents
// -din mod 2^W on dout with a one-cycle done pulse.
// Ports:
//   clk  rising-edge clock
//   res  synchronous active-high reset, priority over start
//   bus  serial_neg_ctrl_if.slave (start, din, busy, done, dout, ovf)
// Timing: done is high after the W-th edge following the accepting edge;
// one word per W+2 cycles when start is held high.
module serial_neg_ctrl
    import serial_neg_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic              clk,
    input  logic              res,
    serial_neg_ctrl_if.slave  bus
);
    localparam int unsigned    CW       = cnt_width(W);
    localparam logic [CW-1:0]  LAST     = CW'(W - 1);
    localparam logic [W-1:0]   MOST_NEG = {1'b1, {(W-1){1'b0}}};

    state_t        state;
    logic [W-1:0]  operand;
    logic [W-1:0]  result;
    logic [W-1:0]  result_next;
    logic [CW-1:0] cnt;
    logic          ovf_cap;
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  dout_r;
    logic          ovf_r;
    logic          load;
    logic          shift_en;
    logic          cell_out;

    always_comb begin
        load        = (state == IDLE) && bus.start;
        shift_en    = (state == SHIFT);
        result_next = {cell_out, result[W-1:1]};
    end

    serial_neg_cell u_cell (
        .clk     (clk),
        .res     (res),
        .clr     (load),
        .en      (shift_en),
        .in_bit  (operand[0]),
        .out_bit (cell_out)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            operand <= '0;
            result  <= '0;
            cnt     <= '0;
            ovf_cap <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dout_r  <= '0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        operand <= bus.din;
                        // overflow is judged on the captured operand only
                        ovf_cap <= (bus.din == MOST_NEG);
                        result  <= '0;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    operand <= operand >> 1;
                    result  <= result_next;
                    cnt     <= cnt + CW'(1);
                    // the last shift writes the completed word straight to
                    // dout so it is valid in the same cycle done rises
                    if (cnt == LAST) begin
                        dout_r <= result_next;
                        ovf_r  <= ovf_cap;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy = busy_r;
        bus.done = done_r;
        bus.dout = dout_r;
        bus.ovf  = ovf_r;
    end
endmodule
